countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 103 ++++++++++
 tb/tb_countdown_timer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable countdown with prescaler, pause/resume, abort and
//                a one-cycle registered expiry pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int N = 4,
    parameter int P = 100000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    output logic [N-1:0] C,
    output logic         T,
    output logic         busy,
    output logic [1:0]   state
);

    localparam int             c_pc_w    = (P > 1) ? $clog2(P) : 1;
    localparam logic [c_pc_w-1:0] c_pc_last = c_pc_w'(P - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_pc_w-1:0]   r_pc;
    logic [N-1:0]        r_count;
    logic                r_t;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_count <= '0;
            r_t     <= 1'b0;
        end else if (load) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_count <= load_val;
            r_t     <= 1'b0;
        end else begin
            r_t <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc <= '0;
                        // Starting from zero expires immediately.
                        if (r_count != '0) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                            r_t     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        r_state <= S_PAUSED;
                    end else if (r_pc == c_pc_last) begin
                        r_pc <= '0;
                        if (r_count != '0) begin
                            r_count <= r_count - 1'b1;
                            if (r_count == N'(1)) begin
                                r_state <= S_DONE;
                                r_t     <= 1'b1;
                            end
                        end
                    end else begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (start && !pause) begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign C     = r_count;
    assign T     = r_t;
    assign state = r_state;
    assign busy  = (r_state == S_RUN) || (r_state == S_PAUSED);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer (N=4, P=3) against a
//                remaining-cycles reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int N = 4;
    localparam int P = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] C;
    logic         T;
    logic         busy;
    logic [1:0]   state;

    countdown_timer #(.N(N), .P(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .C        (C),
        .T        (T),
        .busy     (busy),
        .state    (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: total clock cycles left before expiry, plus the mode number.
    int m_rem  = 0;
    int m_mode = 0;
    int m_t    = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, a, l, input int v, input bit s, p);
        m_t = 0;
        if (r || a) begin
            m_rem  = 0;
            m_mode = 0;
        end else if (l) begin
            m_rem  = v * P;
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (s) begin
                       if (m_rem == 0) begin m_mode = 3; m_t = 1; end
                       else m_mode = 1;
                   end
                1: if (p) m_mode = 2;
                   else begin
                       m_rem--;
                       if (m_rem == 0) begin m_mode = 3; m_t = 1; end
                   end
                2: if (s && !p) m_mode = 1;
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input bit r, a, l, input int v, input bit s, p);
        @(negedge clk);
        rst = r; abort = a; load = l; load_val = N'(v); start = s; pause = p;
        @(posedge clk);
        model_step(r, a, l, v, s, p);
        #1;
        chk("C",     int'(C),     (m_rem + P - 1) / P);
        chk("T",     int'(T),     m_t);
        chk("state", int'(state), m_mode);
        chk("busy",  int'(busy),  (m_mode == 1 || m_mode == 2) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    int first_t;
    int t_count;

    initial begin
        // Reset
        cycle(1, 0, 1, 9, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("rst_C", int'(C), 0);

        // Load 3, start, expiry after 9 cycles
        cycle(0, 0, 1, 3, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        first_t = -1;
        t_count = 0;
        for (int j = 1; j <= 14; j++) begin
            cycle(0, 0, 0, 0, (j > 10) ? 1'b1 : 1'b0, 0);
            if (T) begin
                t_count++;
                if (first_t < 0) first_t = j;
            end
            if (j == 3) chk("C_at_k3", int'(C), 2);
            if (j == 6) chk("C_at_k6", int'(C), 1);
        end
        chk("expiry_latency", first_t, 9);
        chk("expiry_pulses", t_count, 1);
        chk("done_state", int'(state), 3);

        // Start from zero -> immediate DONE
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("zero_start_T", int'(T), 1);
        idle(3);

        // Pause/resume with load 2
        cycle(0, 0, 1, 2, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        idle(4);
        cycle(0, 0, 0, 0, 1, 1);
        for (int j = 0; j < 5; j++) cycle(0, 0, 0, 0, 0, (j % 2 == 0) ? 1'b1 : 1'b0);
        chk("paused_C", int'(C), 1);
        cycle(0, 0, 0, 0, 1, 0);
        idle(1);
        chk("resume_T_early", int'(T), 0);
        idle(1);
        chk("resume_T", int'(T), 1);
        idle(2);

        // Abort beats load mid-run at C=5
        cycle(0, 0, 1, 6, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        idle(4);
        chk("mid_C5", int'(C), 5);
        cycle(0, 1, 1, 9, 1, 0);
        chk("abort_wins", int'(C), 0);
        cycle(0, 0, 1, 9, 0, 0);
        chk("reload_9", int'(C), 9);

        // Load 7 mid-run at C=4
        cycle(0, 0, 0, 0, 1, 0);
        idle(16);
        chk("mid_C4", int'(C), 4);
        cycle(0, 0, 1, 7, 1, 1);
        idle(4);

        // Reset while paused, with start on the same edge
        cycle(0, 0, 1, 5, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        idle(5);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1, 0);
        t_count = 0;
        for (int j = 0; j < 20; j++) begin
            cycle(0, 0, 0, 0, 0, 0);
            if (T) t_count++;
        end
        chk("rst_no_T", t_count, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit r, a, l, s, p;
            r = ($urandom_range(0, 199) == 0);
            a = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 5);
            s = ($urandom_range(0, 99) < 25);
            p = ($urandom_range(0, 99) < 10);
            cycle(r, a, l, int'($urandom_range(0, 15)), s, p);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
